// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipeline control chain.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pipe_pkg;

    // Forward-select code meaning "read from the register file".
    localparam int FWD_RF = 0;

    // Program-counter register address: all ones at any address width.
    // Consumers slice the low AW bits.
    localparam logic [63:0] PC_ADDR = '1;

    // Forward-select width: enough bits to name every stage, never zero.
    function automatic int sel_w(input int stages);
        int c;
        c = $clog2(stages);
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage register holding {valid, we, ld, wa, data}.
// Latency: 1 cycle from d_* to q_* when enabled.
// Backpressure: en=0 holds contents; flush clears regardless of en; bubble loads an empty slot.
// Ports: clk, reset (async active-low clear), en (load), flush (force bubble),
//        bubble (load empty slot instead of d_*), d_* in, q_* out.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              flush,
    input  logic              bubble,
    input  logic              d_valid,
    input  logic              d_we,
    input  logic              d_ld,
    input  logic [AW-1:0]     d_wa,
    input  logic [DATA_W-1:0] d_data,
    output logic              q_valid,
    output logic              q_we,
    output logic              q_ld,
    output logic [AW-1:0]     q_wa,
    output logic [DATA_W-1:0] q_data
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_valid <= 1'b0;
            q_we    <= 1'b0;
            q_ld    <= 1'b0;
            q_wa    <= '0;
            q_data  <= '0;
        end else if (flush || (en && bubble)) begin
            // Flush wins over hold; an upstream hold feeds an empty slot.
            q_valid <= 1'b0;
            q_we    <= 1'b0;
            q_ld    <= 1'b0;
            q_wa    <= '0;
            q_data  <= '0;
        end else if (en) begin
            q_valid <= d_valid;
            q_we    <= d_we;
            q_ld    <= d_ld;
            q_wa    <= d_wa;
            q_data  <= d_data;
        end
    end

endmodule

// File: rtl/pipe_ctrl_chain.sv
// Pipeline control chain: STAGES register stages with per-stage stall/flush, operand forward select and load-use detect.
// Latency: STAGES cycles from in_* to out_* with no stall or flush.
// Backpressure: stall[k] holds stage k; a held stage k-1 feeds bubbles into a moving stage k; flush[k] forces a bubble.
// Ports: clk, reset (async active-low); in_valid/in_we/in_ld/in_wa/in_data decode slot; stall, flush per stage;
//        src_addr (stage 0 sources) -> fwd_sel; dec_addr (decode sources) -> ldstall; out_* last stage; perf_bubbles.
// Optional macro PIPE_CTRL_PERF_EN adds a saturating count of last-stage bubble cycles on perf_bubbles.
module pipe_ctrl_chain
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int STAGES = 3,
    parameter int NRD    = 2,
    parameter int AW     = 4,
    localparam int SELW  = sel_w(STAGES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic                in_we,
    input  logic                in_ld,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [AW-1:0]       in_wa,
    input  logic [STAGES-1:0]   stall,
    input  logic [STAGES-1:0]   flush,
    input  logic [NRD*AW-1:0]   src_addr,
    input  logic [NRD*AW-1:0]   dec_addr,
    output logic [NRD*SELW-1:0] fwd_sel,
    output logic                ldstall,
    output logic                out_valid,
    output logic                out_we,
    output logic [AW-1:0]       out_wa,
    output logic [DATA_W-1:0]   out_data,
    output logic [31:0]         perf_bubbles
);

    localparam logic [AW-1:0] PC = PC_ADDR[AW-1:0];

    logic              s_valid [STAGES];
    logic              s_we    [STAGES];
    logic              s_ld    [STAGES];
    logic [AW-1:0]     s_wa    [STAGES];
    logic [DATA_W-1:0] s_data  [STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic              d_valid;
        logic              d_we;
        logic              d_ld;
        logic [AW-1:0]     d_wa;
        logic [DATA_W-1:0] d_data;
        logic              d_bubble;

        if (k == 0) begin : g_head
            assign d_valid  = in_valid;
            assign d_we     = in_we;
            assign d_ld     = in_ld;
            assign d_wa     = in_wa;
            assign d_data   = in_data;
            assign d_bubble = 1'b0;
        end else begin : g_body
            assign d_valid  = s_valid[k-1];
            assign d_we     = s_we[k-1];
            assign d_ld     = s_ld[k-1];
            assign d_wa     = s_wa[k-1];
            assign d_data   = s_data[k-1];
            assign d_bubble = stall[k-1];
        end

        pipe_stage_reg #(
            .DATA_W (DATA_W),
            .AW     (AW)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .en      (!stall[k]),
            .flush   (flush[k]),
            .bubble  (d_bubble),
            .d_valid (d_valid),
            .d_we    (d_we),
            .d_ld    (d_ld),
            .d_wa    (d_wa),
            .d_data  (d_data),
            .q_valid (s_valid[k]),
            .q_we    (s_we[k]),
            .q_ld    (s_ld[k]),
            .q_wa    (s_wa[k]),
            .q_data  (s_data[k])
        );
    end

    // Scan from the oldest stage toward stage 1 so the nearest producer overwrites.
    always_comb begin
        fwd_sel = {NRD{SELW'(FWD_RF)}};
        for (int p = 0; p < NRD; p++) begin
            for (int k = STAGES - 1; k >= 1; k--) begin
                if (s_valid[k] && s_we[k] &&
                    (s_wa[k] == src_addr[p*AW +: AW]) &&
                    (src_addr[p*AW +: AW] != PC)) begin
                    fwd_sel[p*SELW +: SELW] = SELW'(k);
                end
            end
        end
    end

    // A load in stage 0 cannot forward in time to the decode instruction.
    always_comb begin
        ldstall = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            if (s_valid[0] && s_we[0] && s_ld[0] &&
                (dec_addr[p*AW +: AW] != PC) &&
                (dec_addr[p*AW +: AW] == s_wa[0])) begin
                ldstall = 1'b1;
            end
        end
    end

    assign out_valid = s_valid[STAGES-1];
    assign out_we    = s_we[STAGES-1];
    assign out_wa    = s_wa[STAGES-1];
    assign out_data  = s_data[STAGES-1];

    // The last stage's load flag has no consumer downstream.
    logic unused_last_ld;
    assign unused_last_ld = s_ld[STAGES-1];

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_cnt <= '0;
        end else if (!s_valid[STAGES-1] && (perf_cnt != 32'hFFFF_FFFF)) begin
            perf_cnt <= perf_cnt + 32'd1;
        end
    end

    assign perf_bubbles = perf_cnt;
`else
    assign perf_bubbles = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Directed bench for pipe_ctrl_chain: vector table plus hand sequences for stall, flush, async reset and the bubble counter.
// Latency: n/a.
// Backpressure: n/a.
module tb_pipe_ctrl_chain;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_we;
    logic        in_ld;
    logic [31:0] in_data;
    logic [3:0]  in_wa;
    logic [2:0]  stall;
    logic [2:0]  flush;
    logic [7:0]  src_addr;
    logic [7:0]  dec_addr;
    logic [3:0]  fwd_sel;
    logic        ldstall;
    logic        out_valid;
    logic        out_we;
    logic [3:0]  out_wa;
    logic [31:0] out_data;
    logic [31:0] perf_bubbles;

    int checks;
    int failures;

    pipe_ctrl_chain dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_we        (in_we),
        .in_ld        (in_ld),
        .in_data      (in_data),
        .in_wa        (in_wa),
        .stall        (stall),
        .flush        (flush),
        .src_addr     (src_addr),
        .dec_addr     (dec_addr),
        .fwd_sel      (fwd_sel),
        .ldstall      (ldstall),
        .out_valid    (out_valid),
        .out_we       (out_we),
        .out_wa       (out_wa),
        .out_data     (out_data),
        .perf_bubbles (perf_bubbles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        we;
        logic        ld;
        logic [3:0]  wa;
        logic [31:0] data;
        logic [2:0]  stall;
        logic [2:0]  flush;
        logic [7:0]  src;
        logic [7:0]  dec;
        logic        e_v;
        logic        e_we;
        logic [3:0]  e_wa;
        logic [31:0] e_data;
        logic [3:0]  e_fwd;
        logic        e_ldstall;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic ld,
                         input logic [3:0] wa, input logic [31:0] data);
        in_valid = v;
        in_we    = we;
        in_ld    = ld;
        in_wa    = wa;
        in_data  = data;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic v, input logic we,
                             input logic [3:0] wa, input logic [31:0] data);
        check({name, ".out_valid"}, out_valid, v);
        check({name, ".out_we"},    out_we,    we);
        check({name, ".out_wa"},    out_wa,    wa);
        check({name, ".out_data"},  out_data,  data);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        //            v  we ld wa     data          stall  flush  src    dec    e_v we wa     data          fwd   ldst
        tbl[0]  = '{1, 1, 0, 4'd3,  32'h000000A5, 3'b000, 3'b000, 8'h00, 8'h00, 0, 0, 4'd0,  32'h0,        4'h0, 0};
        tbl[1]  = '{1, 1, 0, 4'd5,  32'h00000011, 3'b000, 3'b000, 8'h03, 8'h00, 0, 0, 4'd0,  32'h0,        4'h0, 0};
        tbl[2]  = '{1, 1, 0, 4'd5,  32'h00000022, 3'b000, 3'b000, 8'h53, 8'h05, 0, 0, 4'd0,  32'h0,        4'h1, 0};
        tbl[3]  = '{0, 0, 0, 4'd0,  32'h0,        3'b000, 3'b000, 8'h35, 8'h00, 1, 1, 4'd3,  32'h000000A5, 4'h9, 0};
        tbl[4]  = '{0, 0, 0, 4'd0,  32'h0,        3'b000, 3'b010, 8'h05, 8'h00, 1, 1, 4'd5,  32'h00000011, 4'h1, 0};
        tbl[5]  = '{1, 1, 1, 4'd7,  32'h00000033, 3'b000, 3'b000, 8'h05, 8'h00, 1, 1, 4'd5,  32'h00000022, 4'h2, 0};
        tbl[6]  = '{1, 1, 1, 4'd15, 32'h00000044, 3'b000, 3'b000, 8'h05, 8'h70, 0, 0, 4'd0,  32'h0,        4'h0, 1};
        tbl[7]  = '{0, 0, 0, 4'd0,  32'h0,        3'b000, 3'b000, 8'hFF, 8'hFF, 0, 0, 4'd0,  32'h0,        4'h0, 0};
        tbl[8]  = '{0, 0, 0, 4'd0,  32'h0,        3'b000, 3'b000, 8'h7F, 8'h00, 1, 1, 4'd7,  32'h00000033, 4'h8, 0};
        tbl[9]  = '{1, 0, 0, 4'd9,  32'h00000055, 3'b000, 3'b000, 8'h00, 8'h00, 1, 1, 4'd15, 32'h00000044, 4'h0, 0};
        tbl[10] = '{0, 0, 0, 4'd0,  32'h0,        3'b000, 3'b000, 8'h09, 8'h00, 0, 0, 4'd0,  32'h0,        4'h0, 0};
        tbl[11] = '{0, 0, 0, 4'd0,  32'h0,        3'b000, 3'b000, 8'h09, 8'h09, 0, 0, 4'd0,  32'h0,        4'h0, 0};

        // Reset state
        reset    = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        stall    = '0;
        flush    = '0;
        src_addr = '0;
        dec_addr = '0;
        @(negedge clk);
        @(negedge clk);
        check_out("reset", 1'b0, 1'b0, 4'd0, 32'd0);
        check("reset.fwd_sel", fwd_sel, 4'h0);
        check("reset.ldstall", ldstall, 1'b0);
        check("reset.perf", perf_bubbles, 32'd0);
        reset = 1'b1;

        // Idle bubbles after reset
        for (int i = 0; i < 10; i++) tick();
`ifdef PIPE_CTRL_PERF_EN
        check("perf.ten_bubbles", perf_bubbles, 32'd10);
        force dut.perf_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.perf_cnt;
        for (int i = 0; i < 3; i++) tick();
        check("perf.saturate", perf_bubbles, 32'hFFFF_FFFF);
`else
        check("perf.disabled", perf_bubbles, 32'd0);
`endif

        // Vector table: drive row, check outputs against current state, then clock
        for (int r = 0; r < 12; r++) begin
            drive(tbl[r].v, tbl[r].we, tbl[r].ld, tbl[r].wa, tbl[r].data);
            stall    = tbl[r].stall;
            flush    = tbl[r].flush;
            src_addr = tbl[r].src;
            dec_addr = tbl[r].dec;
            #1;
            check($sformatf("row%0d.out_valid", r), out_valid, tbl[r].e_v);
            check($sformatf("row%0d.out_we", r),    out_we,    tbl[r].e_we);
            check($sformatf("row%0d.out_wa", r),    out_wa,    tbl[r].e_wa);
            check($sformatf("row%0d.out_data", r),  out_data,  tbl[r].e_data);
            check($sformatf("row%0d.fwd_sel", r),   fwd_sel,   tbl[r].e_fwd);
            check($sformatf("row%0d.ldstall", r),   ldstall,   tbl[r].e_ldstall);
            tick();
        end
        stall = '0;
        flush = '0;

        // Stage 0 held while stage 1 moves: stage 1 fills with bubbles
        drive(1'b1, 1'b1, 1'b1, 4'd2, 32'h77);
        src_addr = 8'h02;
        dec_addr = 8'h02;
        tick();
        check("stall.loaded.ldstall", ldstall, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 4'd4, 32'h88);
        stall = 3'b001;
        tick();
        check("stall.c1.ldstall", ldstall, 1'b1);
        check("stall.c1.fwd_sel", fwd_sel, 4'h0);
        tick();
        check("stall.c2.ldstall", ldstall, 1'b1);
        check("stall.c2.fwd_sel", fwd_sel, 4'h0);
        check("stall.c2.out_valid", out_valid, 1'b0);
        stall = 3'b000;
        tick();
        check("stall.rel.fwd_sel", fwd_sel, 4'h1);
        check("stall.rel.ldstall", ldstall, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 4'd6, 32'h99);
        tick();
        check_out("stall.held_slot", 1'b1, 1'b1, 4'd2, 32'h77);
        dec_addr = 8'h06;
        #1;
        check("flush.pre.ldstall", ldstall, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        stall = 3'b001;
        flush = 3'b001;
        tick();
        check("flush.over_stall.ldstall", ldstall, 1'b0);
        check_out("flush.next_slot", 1'b1, 1'b1, 4'd4, 32'h88);
        stall = '0;
        flush = '0;

        // Asynchronous reset with three slots in flight
        drive(1'b1, 1'b1, 1'b1, 4'd1, 32'h101);
        tick();
        drive(1'b1, 1'b1, 1'b1, 4'd2, 32'h102);
        tick();
        drive(1'b1, 1'b1, 1'b1, 4'd3, 32'h103);
        tick();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        src_addr = 8'h02;
        dec_addr = 8'h03;
        #1;
        check_out("inflight", 1'b1, 1'b1, 4'd1, 32'h101);
        check("inflight.fwd_sel", fwd_sel, 4'h1);
        check("inflight.ldstall", ldstall, 1'b1);
        #1;
        reset = 1'b0;
        #1;
        check_out("arst", 1'b0, 1'b0, 4'd0, 32'd0);
        check("arst.fwd_sel", fwd_sel, 4'h0);
        check("arst.ldstall", ldstall, 1'b0);
        check("arst.perf", perf_bubbles, 32'd0);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("post_rst.c%0d.out_valid", i), out_valid, 1'b0);
        end
        drive(1'b1, 1'b1, 1'b0, 4'd8, 32'hBEEF);
        tick();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        tick();
        check("post_rst.lat2.out_valid", out_valid, 1'b0);
        tick();
        check_out("post_rst.lat3", 1'b1, 1'b1, 4'd8, 32'hBEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
